// File: rtl/mpls_ingress_arb.sv
// Round-robin packet arbiter that merges NUM_PORTS AXI-Stream ingress ports onto one wide bus.
// Packets longer than the MTU are cut at the MTU beat. The rest of the packet is drained and dropped.
module mpls_ingress_arb #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_BYTES = 64,
  parameter int MTU_BYTES  = 9600,
  localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                               clk,
  input  logic                               sresetn,
  input  logic [NUM_PORTS-1:0]               in_tvalid,
  output logic [NUM_PORTS-1:0]               in_tready,
  input  logic [NUM_PORTS*DATA_BYTES*8-1:0]  in_tdata,
  input  logic [NUM_PORTS*DATA_BYTES-1:0]    in_tkeep,
  input  logic [NUM_PORTS-1:0]               in_tlast,
  output logic                               out_tvalid,
  input  logic                               out_tready,
  output logic [DATA_BYTES*8-1:0]            out_tdata,
  output logic [DATA_BYTES-1:0]              out_tkeep,
  output logic                               out_tlast,
  output logic [IDX_W-1:0]                   out_tuser,
  output logic                               oversize_pulse,
  output logic [15:0]                        oversize_count
);

  localparam int DW        = DATA_BYTES * 8;
  localparam int MTU_BEATS = (MTU_BYTES + DATA_BYTES - 1) / DATA_BYTES;
  localparam int CNT_W     = $clog2(MTU_BEATS + 1);
  localparam logic [CNT_W-1:0] MTU_LAST  = CNT_W'(MTU_BEATS);
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {IDLE, PASS, DISCARD} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0] rr_reg, rr_next, rr_pick, rr_after;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             any_valid;
  logic             out_free, accept, trunc;
  logic             sel_valid, sel_last;
  logic [DW-1:0]    sel_data;
  logic [DATA_BYTES-1:0] sel_keep;
  int               cand;
  logic [IDX_W-1:0] cidx;

  logic [DW-1:0]         data_arr [NUM_PORTS];
  logic [DATA_BYTES-1:0] keep_arr [NUM_PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_split
      assign data_arr[gi] = in_tdata[gi*DW +: DW];
      assign keep_arr[gi] = in_tkeep[gi*DATA_BYTES +: DATA_BYTES];
    end
  endgenerate

  assign sel_valid = in_tvalid[grant_reg];
  assign sel_last  = in_tlast[grant_reg];
  assign sel_data  = data_arr[grant_reg];
  assign sel_keep  = keep_arr[grant_reg];
  assign out_free  = !out_tvalid || out_tready;
  assign rr_after  = (grant_reg == LAST_PORT) ? '0 : grant_reg + 1'b1;

  // Walk offsets from highest to lowest so the nearest valid port above rr_reg wins.
  always_comb begin
    rr_pick   = rr_reg;
    any_valid = 1'b0;
    cand      = 0;
    cidx      = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      cand = int'(rr_reg) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cidx = IDX_W'(cand);
      if (in_tvalid[cidx]) begin
        rr_pick   = cidx;
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    rr_next    = rr_reg;
    cnt_next   = cnt_reg;
    in_tready  = '0;
    accept     = 1'b0;
    trunc      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          grant_next = rr_pick;
          cnt_next   = '0;
          state_next = PASS;
        end
      end
      PASS: begin
        in_tready[grant_reg] = out_free;
        if (sel_valid && out_free) begin
          accept   = 1'b1;
          cnt_next = cnt_reg + 1'b1;
          if (sel_last) begin
            rr_next    = rr_after;
            state_next = IDLE;
          end else if (cnt_reg + 1'b1 == MTU_LAST) begin
            trunc      = 1'b1;
            state_next = DISCARD;
          end
        end
      end
      DISCARD: begin
        // Tail of an oversize packet is drained regardless of downstream backpressure.
        in_tready[grant_reg] = 1'b1;
        if (sel_valid && sel_last) begin
          rr_next    = rr_after;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      rr_reg         <= '0;
      cnt_reg        <= '0;
      out_tvalid     <= 1'b0;
      out_tlast      <= 1'b0;
      out_tuser      <= '0;
      out_tdata      <= '0;
      out_tkeep      <= '0;
      oversize_pulse <= 1'b0;
      oversize_count <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      rr_reg         <= rr_next;
      cnt_reg        <= cnt_next;
      oversize_pulse <= trunc;
      if (trunc && oversize_count != 16'hFFFF) oversize_count <= oversize_count + 16'd1;
      if (accept) begin
        out_tvalid <= 1'b1;
        out_tdata  <= sel_data;
        out_tkeep  <= sel_keep;
        out_tlast  <= sel_last || trunc;
        out_tuser  <= grant_reg;
      end else if (out_tready) begin
        out_tvalid <= 1'b0;
      end
    end
  end

endmodule
